// File: rtl/control_unit_mc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, datapath
// mux-select codes and instruction opcodes.
package control_unit_mc_pkg;

    localparam int unsigned STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET   = 5'b00001,
        ST_FETCH   = 5'b00010,
        ST_EXECUTE = 5'b00100,
        ST_IRQ     = 5'b01000,
        ST_HALT    = 5'b10000
    } state_t;

    localparam logic [1:0] ADDR_SEL_IR  = 2'b00;
    localparam logic [1:0] ADDR_SEL_ACC = 2'b01;
    localparam logic [1:0] ADDR_SEL_PC  = 2'b10;

    localparam logic [2:0] PC_SEL_INC   = 3'b000;
    localparam logic [2:0] PC_SEL_ACC   = 3'b001;
    localparam logic [2:0] PC_SEL_BACK3 = 3'b010;
    localparam logic [2:0] PC_SEL_SKIP2 = 3'b011;
    localparam logic [2:0] PC_SEL_VEC   = 3'b100;
    localparam logic [2:0] PC_SEL_EPC   = 3'b101;

    localparam logic [1:0] ACC_SEL_ALU = 2'b00;
    localparam logic [1:0] ACC_SEL_MEM = 2'b01;
    localparam logic [1:0] ACC_SEL_PC  = 2'b10;

    localparam logic [2:0] OPC_LDA = 3'b000;
    localparam logic [2:0] OPC_STA = 3'b001;
    localparam logic [2:0] OPC_EXT = 3'b111;

    localparam logic [7:0] OP_ACC_LAST = 8'hF4;
    localparam logic [7:0] OP_EI       = 8'hF5;
    localparam logic [7:0] OP_DI       = 8'hF6;
    localparam logic [7:0] OP_RETI     = 8'hF7;
    localparam logic [7:0] OP_BEQ_FWD  = 8'hF8;
    localparam logic [7:0] OP_BEQ_BWD  = 8'hF9;
    localparam logic [7:0] OP_BNE_FWD  = 8'hFA;
    localparam logic [7:0] OP_BNE_BWD  = 8'hFB;
    localparam logic [7:0] OP_LDAR     = 8'hFC;
    localparam logic [7:0] OP_JMP      = 8'hFD;
    localparam logic [7:0] OP_JSR      = 8'hFE;
    localparam logic [7:0] OP_HLT      = 8'hFF;

    // Instructions that wait on the memory handshake during EXECUTE.
    function automatic logic is_mem_op(input logic [7:0] ins);
        return (ins[7:5] != OPC_EXT) || (ins == OP_LDAR);
    endfunction

endpackage

// File: rtl/control_unit_mc_irq_prio_enc.sv
// Fixed-priority interrupt encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic [N_IRQ-1:0] onehot
);

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (req[i] && !valid) begin
                valid     = 1'b1;
                index     = IDX_W'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_register.sv
// Parallel-load register with a serial scan path; shift takes priority
// over load, and the MSB is presented on serial_out.
module shift_register #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= RESET_VALUE;
        else if (shift)
            q <= {q[WIDTH-2:0], serial_in};
        else if (load)
            q <= d;
    end

    assign serial_out = q[WIDTH-1];

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle fetch/execute sequencer with memory wait states, prioritised
// interrupts (EPC, IE, wake-from-halt) and a scannable state/IE/EPC chain.
module control_unit_mc
    import control_unit_mc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned N_IRQ    = 4,
    parameter int unsigned VEC_BASE = 'h18,
    parameter bit          IE_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              processor_enable,
    input  logic [7:0]        instruction,
    input  logic              ZF,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_ready,
    input  logic [N_IRQ-1:0]  irq,
    output logic              mem_req,
    output logic              mem_write_enable,
    output logic [1:0]        mem_addr_mux_select,
    output logic              pc_write_enable,
    output logic [2:0]        pc_mux_select,
    output logic              acc_write_enable,
    output logic [1:0]        acc_mux_select,
    output logic              ir_load_enable,
    output logic [N_IRQ-1:0]  irq_ack,
    output logic [ADDR_W-1:0] irq_vector,
    output logic [ADDR_W-1:0] epc,
    output logic              processor_halted,
    input  logic              scan_enable,
    input  logic              scan_in,
    output logic              scan_out
);

    localparam int unsigned CHAIN_W   = STATE_W + 1 + ADDR_W;
    localparam int unsigned IRQ_IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [CHAIN_W-1:0] CHAIN_RST = {ST_RESET, IE_RESET, {ADDR_W{1'b0}}};

    logic [CHAIN_W-1:0]   chain_q, chain_d;
    state_t               state, nxt_state;
    logic                 ie, nxt_ie;
    logic [ADDR_W-1:0]    nxt_epc;
    logic                 irq_valid;
    logic [IRQ_IDX_W-1:0] irq_idx;
    logic [N_IRQ-1:0]     irq_onehot;

    logic                 req_c, mem_we_c, pc_we_c, acc_we_c, ir_ld_c, ack_c, halt_c;
    logic                 done, mem_op;
    logic [1:0]           addr_sel_c, acc_sel_c;
    logic [2:0]           pc_sel_c;
    logic                 strobe_en;

    // State, IE and EPC live in one register so they form a single scan chain.
    shift_register #(
        .WIDTH       (CHAIN_W),
        .RESET_VALUE (CHAIN_RST)
    ) u_state_chain (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (processor_enable),
        .shift      (scan_enable),
        .d          (chain_d),
        .serial_in  (scan_in),
        .q          (chain_q),
        .serial_out (scan_out)
    );

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .IDX_W (IRQ_IDX_W)
    ) u_irq_prio_enc (
        .req    (irq),
        .valid  (irq_valid),
        .index  (irq_idx),
        .onehot (irq_onehot)
    );

    assign state      = state_t'(chain_q[CHAIN_W-1 -: STATE_W]);
    assign ie         = chain_q[ADDR_W];
    assign epc        = chain_q[ADDR_W-1:0];
    assign chain_d    = {nxt_state, nxt_ie, nxt_epc};
    assign irq_vector = ADDR_W'(VEC_BASE) + ADDR_W'(irq_idx);

    always_comb begin
        nxt_state  = state;
        nxt_ie     = ie;
        nxt_epc    = epc;
        req_c      = 1'b0;
        mem_we_c   = 1'b0;
        pc_we_c    = 1'b0;
        acc_we_c   = 1'b0;
        ir_ld_c    = 1'b0;
        ack_c      = 1'b0;
        halt_c     = 1'b0;
        addr_sel_c = ADDR_SEL_IR;
        pc_sel_c   = PC_SEL_INC;
        acc_sel_c  = ACC_SEL_ALU;
        done       = 1'b1;
        mem_op     = is_mem_op(instruction);

        case (state)
            ST_RESET: nxt_state = ST_FETCH;

            ST_FETCH: begin
                req_c      = 1'b1;
                addr_sel_c = ADDR_SEL_PC;
                if (mem_ready) begin
                    ir_ld_c   = 1'b1;
                    pc_we_c   = 1'b1;
                    nxt_state = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                if (mem_op) begin
                    req_c      = 1'b1;
                    done       = mem_ready;
                    addr_sel_c = (instruction == OP_LDAR) ? ADDR_SEL_ACC : ADDR_SEL_IR;
                end
                if (instruction[7:5] != OPC_EXT) begin
                    case (instruction[7:5])
                        OPC_LDA: begin
                            acc_sel_c = ACC_SEL_MEM;
                            acc_we_c  = mem_ready;
                        end
                        OPC_STA: mem_we_c = mem_ready;
                        default: acc_we_c = mem_ready;
                    endcase
                end else if (!instruction[4] || instruction <= OP_ACC_LAST) begin
                    acc_we_c = 1'b1;
                end else begin
                    case (instruction)
                        OP_EI:   nxt_ie = 1'b1;
                        OP_DI:   nxt_ie = 1'b0;
                        OP_RETI: begin
                            pc_we_c  = 1'b1;
                            pc_sel_c = PC_SEL_EPC;
                            nxt_ie   = 1'b1;
                        end
                        OP_BEQ_FWD: begin
                            pc_we_c  = ZF;
                            pc_sel_c = PC_SEL_SKIP2;
                        end
                        OP_BEQ_BWD: begin
                            pc_we_c  = ZF;
                            pc_sel_c = PC_SEL_BACK3;
                        end
                        OP_BNE_FWD: begin
                            pc_we_c  = !ZF;
                            pc_sel_c = PC_SEL_SKIP2;
                        end
                        OP_BNE_BWD: begin
                            pc_we_c  = !ZF;
                            pc_sel_c = PC_SEL_BACK3;
                        end
                        OP_LDAR: begin
                            acc_sel_c = ACC_SEL_MEM;
                            acc_we_c  = mem_ready;
                        end
                        OP_JMP: begin
                            pc_we_c  = 1'b1;
                            pc_sel_c = PC_SEL_ACC;
                        end
                        OP_JSR: begin
                            pc_we_c   = 1'b1;
                            pc_sel_c  = PC_SEL_ACC;
                            acc_we_c  = 1'b1;
                            acc_sel_c = ACC_SEL_PC;
                        end
                        default: ;
                    endcase
                end
                // Use the post-instruction IE so EI can admit a pending irq at once.
                if (done) begin
                    if (instruction == OP_HLT)
                        nxt_state = ST_HALT;
                    else if (nxt_ie && irq_valid)
                        nxt_state = ST_IRQ;
                    else
                        nxt_state = ST_FETCH;
                end
            end

            ST_IRQ: begin
                pc_we_c   = 1'b1;
                pc_sel_c  = PC_SEL_VEC;
                ack_c     = 1'b1;
                nxt_epc   = pc_in;
                nxt_ie    = 1'b0;
                nxt_state = ST_FETCH;
            end

            ST_HALT: begin
                halt_c = 1'b1;
                if (ie && irq_valid)
                    nxt_state = ST_IRQ;
            end

            default: nxt_state = ST_FETCH;
        endcase
    end

    assign strobe_en = rst_n && processor_enable && !scan_enable;

    assign mem_req             = req_c && strobe_en;
    assign mem_write_enable    = mem_we_c && strobe_en;
    assign pc_write_enable     = pc_we_c && strobe_en;
    assign acc_write_enable    = acc_we_c && strobe_en;
    assign ir_load_enable      = ir_ld_c && strobe_en;
    assign irq_ack             = (ack_c && strobe_en) ? irq_onehot : '0;
    assign mem_addr_mux_select = addr_sel_c;
    assign pc_mux_select       = pc_sel_c;
    assign acc_mux_select      = acc_sel_c;
    assign processor_halted    = halt_c;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_control_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n, processor_enable, ZF, mem_ready, scan_enable, scan_in;
    logic [7:0] instruction;
    logic [4:0] pc_in;
    logic [3:0] irq;
    logic       mem_req, mem_write_enable, pc_write_enable, acc_write_enable;
    logic       ir_load_enable, processor_halted, scan_out;
    logic [1:0] mem_addr_mux_select, acc_mux_select;
    logic [2:0] pc_mux_select;
    logic [3:0] irq_ack;
    logic [4:0] irq_vector, epc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      nm;
        bit         cstr;
        logic       req, we, pcwe, accwe, irld, halted;
        logic [1:0] asel, accsel;
        logic [2:0] psel;
        logic [3:0] ack;
        bit         cepc, cvec, cscan;
        logic [4:0] epc, vec;
        logic       scan;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    control_unit_mc #(
        .ADDR_W   (5),
        .N_IRQ    (4),
        .VEC_BASE ('h18),
        .IE_RESET (1'b0)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .processor_enable    (processor_enable),
        .instruction         (instruction),
        .ZF                  (ZF),
        .pc_in               (pc_in),
        .mem_ready           (mem_ready),
        .irq                 (irq),
        .mem_req             (mem_req),
        .mem_write_enable    (mem_write_enable),
        .mem_addr_mux_select (mem_addr_mux_select),
        .pc_write_enable     (pc_write_enable),
        .pc_mux_select       (pc_mux_select),
        .acc_write_enable    (acc_write_enable),
        .acc_mux_select      (acc_mux_select),
        .ir_load_enable      (ir_load_enable),
        .irq_ack             (irq_ack),
        .irq_vector          (irq_vector),
        .epc                 (epc),
        .processor_halted    (processor_halted),
        .scan_enable         (scan_enable),
        .scan_in             (scan_in),
        .scan_out            (scan_out)
    );

    function automatic exp_t mk(string nm, logic req, logic [1:0] asel, logic we,
                                logic pcwe, logic [2:0] psel, logic accwe,
                                logic [1:0] accsel, logic irld, logic [3:0] ack,
                                logic halted);
        exp_t e;
        e.nm = nm; e.cstr = 1'b1;
        e.req = req; e.asel = asel; e.we = we; e.pcwe = pcwe; e.psel = psel;
        e.accwe = accwe; e.accsel = accsel; e.irld = irld; e.ack = ack;
        e.halted = halted;
        e.cepc = 1'b0; e.cvec = 1'b0; e.cscan = 1'b0;
        e.epc = '0; e.vec = '0; e.scan = 1'b0;
        return e;
    endfunction

    function automatic exp_t idle(string nm);
        return mk(nm, 0, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 0);
    endfunction

    function automatic exp_t fe(string nm, logic rdy);
        return mk(nm, 1, 2'b10, 0, rdy, 3'b000, 0, 2'b00, rdy, 4'h0, 0);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Drive one cycle's inputs just after the active edge.
    task automatic cyc(logic [7:0] ins, logic rdy, logic z, logic [4:0] pc, logic [3:0] rq);
        @(posedge clk); #1;
        instruction = ins; mem_ready = rdy; ZF = z; pc_in = pc; irq = rq;
    endtask

    task automatic put(exp_t e);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cstr)
                chk({e.nm, " strobes"},
                    32'({mem_req, mem_write_enable, pc_write_enable, acc_write_enable,
                         ir_load_enable, irq_ack, processor_halted}),
                    32'({e.req, e.we, e.pcwe, e.accwe, e.irld, e.ack, e.halted}));
            if (e.cstr && e.req)   chk({e.nm, " addr_sel"}, 32'(mem_addr_mux_select), 32'(e.asel));
            if (e.cstr && e.pcwe)  chk({e.nm, " pc_sel"},   32'(pc_mux_select),       32'(e.psel));
            if (e.cstr && e.accwe) chk({e.nm, " acc_sel"},  32'(acc_mux_select),      32'(e.accsel));
            if (e.cepc)  chk({e.nm, " epc"},      32'(epc),        32'(e.epc));
            if (e.cvec)  chk({e.nm, " vector"},   32'(irq_vector), 32'(e.vec));
            if (e.cscan) chk({e.nm, " scan_out"}, 32'(scan_out),   32'(e.scan));
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t        e;
        logic [10:0] pat;
        pat = 11'b101_1001_1101;
        rst_n = 1'b0; processor_enable = 1'b1; instruction = '0; ZF = 1'b0;
        pc_in = '0; mem_ready = 1'b0; irq = '0; scan_enable = 1'b0; scan_in = 1'b0;

        // Reset state
        cyc(8'h00, 0, 0, 5'h00, 4'h0);
        e = idle("reset"); e.cepc = 1; e.epc = 5'h00; e.cvec = 1; e.vec = 5'h18; put(e);
        cyc(8'h00, 0, 0, 5'h00, 4'h0); rst_n = 1'b1;
        put(idle("reset_state"));

        // LDA 0x03 with two wait cycles
        cyc(8'h03, 1, 0, 5'h00, 4'h0); put(fe("lda_fetch", 1));
        cyc(8'h03, 0, 0, 5'h01, 4'h0); put(mk("lda_wait1", 1, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 0));
        cyc(8'h03, 0, 0, 5'h01, 4'h0); put(mk("lda_wait2", 1, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 0));
        cyc(8'h03, 1, 0, 5'h01, 4'h0); put(mk("lda_done", 1, 2'b00, 0, 0, 3'b000, 1, 2'b01, 0, 4'h0, 0));

        // Branches
        cyc(8'hFB, 1, 0, 5'h01, 4'h0); put(fe("bnebwd_fetch", 1));
        cyc(8'hFB, 0, 0, 5'h02, 4'h0); put(mk("bnebwd_zf0", 0, 2'b00, 0, 1, 3'b010, 0, 2'b00, 0, 4'h0, 0));
        cyc(8'hFB, 1, 1, 5'h02, 4'h0); put(fe("bnebwd_fetch2", 1));
        cyc(8'hFB, 0, 1, 5'h03, 4'h0); put(idle("bnebwd_zf1"));
        cyc(8'hF8, 1, 1, 5'h03, 4'h0); put(fe("beqfwd_fetch", 1));
        cyc(8'hF8, 0, 1, 5'h04, 4'h0); put(mk("beqfwd_zf1", 0, 2'b00, 0, 1, 3'b011, 0, 2'b00, 0, 4'h0, 0));

        // JSR and zero-wait STA
        cyc(8'hFE, 1, 0, 5'h04, 4'h0); put(fe("jsr_fetch", 1));
        cyc(8'hFE, 0, 0, 5'h05, 4'h0); put(mk("jsr_exec", 0, 2'b00, 0, 1, 3'b001, 1, 2'b10, 0, 4'h0, 0));
        cyc(8'h25, 1, 0, 5'h05, 4'h0); put(fe("sta_fetch", 1));
        cyc(8'h25, 1, 0, 5'h06, 4'h0); put(mk("sta_exec", 1, 2'b00, 1, 0, 3'b000, 0, 2'b00, 0, 4'h0, 0));

        // EI, then irq during the next instruction's fetch
        cyc(8'hF5, 1, 0, 5'h06, 4'h0); put(fe("ei_fetch", 1));
        cyc(8'hF5, 0, 0, 5'h07, 4'h0); put(idle("ei_exec"));
        cyc(8'h45, 0, 0, 5'h07, 4'b0110); put(fe("alu_fetch_wait", 0));
        cyc(8'h45, 1, 0, 5'h07, 4'b0110); put(fe("alu_fetch", 1));
        cyc(8'h45, 0, 0, 5'h08, 4'b0110); put(mk("alu_wait", 1, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 0));
        cyc(8'h45, 1, 0, 5'h08, 4'b0110); put(mk("alu_done", 1, 2'b00, 0, 0, 3'b000, 1, 2'b00, 0, 4'h0, 0));
        cyc(8'h45, 0, 0, 5'h0A, 4'b0110);
        e = mk("irq_entry", 0, 2'b00, 0, 1, 3'b100, 0, 2'b00, 0, 4'b0010, 0); e.cvec = 1; e.vec = 5'h19; put(e);

        // RETI from the handler
        cyc(8'hF7, 1, 0, 5'h19, 4'h0);
        e = fe("handler_fetch", 1); e.cepc = 1; e.epc = 5'h0A; put(e);
        cyc(8'hF7, 0, 0, 5'h1A, 4'h0);
        e = mk("reti_exec", 0, 2'b00, 0, 1, 3'b101, 0, 2'b00, 0, 4'h0, 0); e.cepc = 1; e.epc = 5'h0A; put(e);

        // HLT with IE=1, woken by irq[3]
        cyc(8'hFF, 1, 0, 5'h0A, 4'h0); put(fe("hlt_fetch", 1));
        cyc(8'hFF, 0, 0, 5'h0B, 4'h0); put(idle("hlt_exec"));
        cyc(8'hFF, 0, 0, 5'h0C, 4'h0); put(mk("halted", 0, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 1));
        cyc(8'hFF, 0, 0, 5'h0C, 4'b1000);
        e = mk("halt_irq", 0, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 1); e.cvec = 1; e.vec = 5'h1B; put(e);
        cyc(8'hFF, 0, 0, 5'h0C, 4'b1000);
        e = mk("wake_irq", 0, 2'b00, 0, 1, 3'b100, 0, 2'b00, 0, 4'b1000, 0); e.cvec = 1; e.vec = 5'h1B; put(e);

        // processor_enable low freezes and silences; resumes in FETCH
        cyc(8'hFD, 1, 0, 5'h1B, 4'h0); processor_enable = 1'b0;
        e = idle("disabled"); e.cepc = 1; e.epc = 5'h0C; put(e);
        cyc(8'hFD, 1, 0, 5'h1B, 4'h0); processor_enable = 1'b1; put(fe("enable_resume", 1));
        cyc(8'hFD, 0, 0, 5'h1C, 4'h0); put(mk("jmp_exec", 0, 2'b00, 0, 1, 3'b001, 0, 2'b00, 0, 4'h0, 0));

        // DI: pending irq must not be taken
        cyc(8'hF6, 1, 0, 5'h04, 4'h0); put(fe("di_fetch", 1));
        cyc(8'hF6, 0, 0, 5'h05, 4'b0001); put(idle("di_exec"));
        cyc(8'h22, 0, 0, 5'h05, 4'b0001); put(fe("di_no_irq", 0));

        // Reset during STA wait
        cyc(8'h22, 1, 0, 5'h05, 4'h0); put(fe("sta2_fetch", 1));
        cyc(8'h22, 0, 0, 5'h06, 4'h0); put(mk("sta2_wait", 1, 2'b00, 0, 0, 3'b000, 0, 2'b00, 0, 4'h0, 0));
        cyc(8'h22, 1, 0, 5'h06, 4'h0); rst_n = 1'b0; put(idle("sta2_rst"));
        cyc(8'h22, 1, 0, 5'h06, 4'h0); rst_n = 1'b1;
        e = idle("sta2_reset_state"); e.cepc = 1; e.epc = 5'h00; put(e);
        cyc(8'h22, 0, 0, 5'h00, 4'h0); put(fe("post_reset_fetch", 0));

        // Scan a pattern through the 11-bit chain
        for (int i = 0; i < 22; i++) begin
            cyc(8'h00, 0, 0, 5'h00, 4'h0);
            scan_enable = 1'b1;
            scan_in = (i < 11) ? pat[10 - i] : 1'b0;
            if (i == 0)
                put(idle("scan_quiet"));
            if (i >= 11) begin
                e = idle($sformatf("scan_bit%0d", i - 11));
                e.cstr = 1'b0; e.cscan = 1; e.scan = pat[21 - i];
                put(e);
            end
        end
        // Chain is now all zeros: invalid state recovers to FETCH
        cyc(8'h00, 0, 0, 5'h00, 4'h0); scan_enable = 1'b0;
        e = idle("scan_invalid_state"); e.cepc = 1; e.epc = 5'h00; put(e);
        cyc(8'h00, 0, 0, 5'h00, 4'h0); put(fe("invalid_to_fetch", 0));

        cyc(8'h00, 0, 0, 5'h00, 4'h0);
        cyc(8'h00, 0, 0, 5'h00, 4'h0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multi-cycle, parametrised successor to the processor control unit. It sequences fetch/execute with a ready/request memory handshake, so memories may insert wait states. It adds N_IRQ prioritised interrupt lines with a saved return address (EPC) and wake-from-halt. It drives the existing PC/ACC/IR/memory datapath muxes; the ALU opcode stays with the separate ISA decoder. Its state, IE flag and EPC sit on the scan chain.

## Interface
- ADDR_W, 5: PC/EPC/vector width.
- N_IRQ, 4: interrupt lines; index 0 is highest priority.
- VEC_BASE, 5'h18: vector for line i is VEC_BASE + i, modulo 2^ADDR_W.
- IE_RESET, 0: IE flag value after reset.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous, active-low reset.
- processor_enable in 1: 0 freezes all state and forces every strobe to 0.
- instruction in 8: IR contents.
- ZF in 1: ACC==0.
- pc_in in ADDR_W: current PC (EPC capture).
- mem_ready in 1: memory completes the current request this cycle.
- irq in N_IRQ: level-sensitive requests.
- mem_req out 1: memory access requested.
- mem_write_enable out 1: STA write strobe.
- mem_addr_mux_select out 2: 00 IR[4:0], 01 ACC, 10 PC.
- pc_write_enable out 1; pc_mux_select out 3: 000 PC+1, 001 ACC, 010 PC-3, 011 PC+2, 100 irq_vector, 101 EPC.
- acc_write_enable out 1; acc_mux_select out 2: 00 ALU, 01 memory, 10 PC.
- ir_load_enable out 1.
- irq_ack out N_IRQ: one-hot, one cycle.
- irq_vector out ADDR_W; epc out ADDR_W.
- processor_halted out 1.
- scan_enable in 1, scan_in in 1, scan_out out 1.

## Operation
- States, one-hot 5 bits: RESET, FETCH, EXECUTE, IRQ, HALT.
- Reset values:
  - State = RESET; IE = IE_RESET; EPC = 0.
  - All strobes 0; irq_ack = 0; processor_halted = 0.
  - All mux selects 0. irq_vector is combinational.
- RESET -> FETCH on the next enabled cycle.
- FETCH:
  - Drives mem_req=1 and addr_sel=10.
  - On mem_ready: ir_load_enable=1, pc_write_enable=1 (PC+1), go to EXECUTE. Otherwise stay.
- EXECUTE, by instruction:
  - 000aaaaa LDA: acc<=mem.
  - 001aaaaa STA: mem_we.
  - 010–110 prefix: ALU op with memory operand; acc<=ALU.
  - 1110iiii ADDI: acc<=ALU.
  - 11110000–11110100: ACC manipulation; acc<=ALU.
  - 11110101 EI: IE<=1. 11110110 DI: IE<=0.
  - 11110111 RETI: pc<=EPC, IE<=1.
  - 11111000 BEQ_FWD (PC+2 if ZF); 11111001 BEQ_BWD (PC-3 if ZF).
  - 11111010 BNE_FWD (PC+2 if !ZF); 11111011 BNE_BWD (PC-3 if !ZF).
  - 11111100 LDAR: addr_sel=01, acc<=mem.
  - 11111101 JMP: pc<=ACC.
  - 11111110 JSR: pc<=ACC and acc<=PC in the same cycle.
  - 11111111 HLT: go to HALT.
- Memory-operand instructions (LDA, STA, ALU-mem, LDAR):
  - Hold mem_req and addr_sel until mem_ready.
  - The ACC/mem write strobe fires only in the mem_ready cycle.
  - Then leave EXECUTE.
- Other instructions complete in one cycle with mem_req=0.
- Leaving EXECUTE (except HLT): go to IRQ if IE && |irq, else FETCH.
- IRQ (1 cycle):
  - EPC<=pc_in; IE<=0.
  - pc_write_enable=1, pc_mux_select=100.
  - irq_ack = one-hot of the lowest set index; then FETCH.
- HALT:
  - processor_halted=1.
  - If IE && |irq: go to IRQ, with EPC = halted PC (wake).
  - Otherwise stay until reset.
- Invalid state encoding: go to FETCH.

## Timing
- Zero-wait memory: FETCH and EXECUTE take 1 cycle each, so 2 cycles per instruction. Each wait cycle adds 1.
- Interrupt entry adds exactly 1 cycle. The first vector instruction is fetched the cycle after IRQ.
- irq arriving while in FETCH or mid-wait is not taken until the end of EXECUTE.
- An instruction in progress is never aborted.
- EI then immediate irq: taken at the end of the EI EXECUTE.
- rst_n low in any state, including a mid-wait: RESET on the next edge. Any pending memory access is abandoned (mem_req=0).
- processor_enable=0:
  - State, IE and EPC hold; strobes are 0.
  - When enable returns, the block resumes in the held state.
- Scan:
  - While scan_enable=1, state, IE and EPC shift (MSB-first, 5+1+ADDR_W bits) in place of the functional update.
  - scan_out = last bit of the chain.

## Structure
- Shared package holds:
  - state one-hot localparams;
  - pc/acc/addr mux-select codes;
  - opcode constants.
- Sub-module: irq_prio_enc, a parametrised N_IRQ lowest-index-first encoder giving valid, index and one-hot.
- The state register reuses the existing shift_register.

## Test plan
- Reset, then LDA 0x03 with mem_ready low for 2 cycles -> acc_write_enable pulses only in the 3rd EXECUTE cycle, with acc_mux_select=01.
- BNE_BWD with ZF=0 -> pc_mux_select=010 and pc_write_enable=1. With ZF=1 -> pc_write_enable=0.
- EI; then irq=4'b0110 during FETCH of the next instruction:
  - IRQ is entered after that instruction's EXECUTE.
  - irq_ack=0010, irq_vector=0x19, EPC=pc_in.
- RETI after the handler -> pc_mux_select=101, IE=1, and fetch resumes at EPC.
- HLT with IE=1 -> processor_halted=1. irq[3] rising -> IRQ with vector 0x1B.
- rst_n low mid-wait during STA -> mem_write_enable never pulses and the state is RESET.
- Scan-shift a pattern through -> identical bits on scan_out after 5+1+ADDR_W cycles.
